// File: rtl/slc3_pkg.sv
// Shared SLC3 datapath definitions: PC source encodings, condition-code
// bit positions and default reset values.
package slc3_pkg;

    typedef enum logic [1:0] {
        PCMUX_INC  = 2'b00,
        PCMUX_BUS  = 2'b01,
        PCMUX_ADDR = 2'b10,
        PCMUX_RSVD = 2'b11
    } pcmux_e;

    // Bit positions inside the {N,Z,P} condition-code vector
    localparam int NZP_N = 2;
    localparam int NZP_Z = 1;
    localparam int NZP_P = 0;

    localparam logic [15:0] DEFAULT_RESET_PC  = 16'h0000;
    localparam logic [2:0]  DEFAULT_RESET_NZP = 3'b010;

endpackage

// File: rtl/cc_gen.sv
// Condition-code encoder: classifies a 16-bit two's-complement value as
// negative, zero or positive. Exactly one output bit is set.
module cc_gen
    import slc3_pkg::*;
(
    input  logic [15:0] bus,
    output logic [2:0]  nzp
);

    logic is_zero;

    assign is_zero = (bus == 16'h0000);

    // One-hot sign classification of the bus value
    always_comb begin
        nzp        = 3'b000;
        nzp[NZP_N] = bus[15];
        nzp[NZP_Z] = is_zero;
        nzp[NZP_P] = !bus[15] && !is_zero;
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter, NZP condition codes and branch-enable flag for the SLC3
// datapath. Load strobes come from the control FSM; each register acts
// independently on its own strobe.
module pc_branch_unit
    import slc3_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [2:0]  RESET_NZP = DEFAULT_RESET_NZP
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        LD_PC,
    input  logic [1:0]  PCMUX,
    input  logic        LD_CC,
    input  logic        LD_BEN,
    input  logic [15:0] BUS,
    input  logic [15:0] offset,
    input  logic [15:0] IR,
    output logic [15:0] PC,
    output logic [15:0] PC_next,
    output logic [2:0]  NZP,
    output logic        BEN
);

    logic [2:0] nzp_bus;
    logic       ben_next;

    cc_gen u_cc_gen (
        .bus (BUS),
        .nzp (nzp_bus)
    );

    // PC source select; the reserved encoding feeds PC back so a load holds
    always_comb begin
        PC_next = PC;
        case (pcmux_e'(PCMUX))
            PCMUX_INC:  PC_next = PC + 16'd1;
            PCMUX_BUS:  PC_next = BUS;
            PCMUX_ADDR: PC_next = offset;
            default:    PC_next = PC;
        endcase
    end

    // Branch condition evaluated against the codes held before this edge
    assign ben_next = (IR[11] & NZP[NZP_N])
                    | (IR[10] & NZP[NZP_Z])
                    | (IR[9]  & NZP[NZP_P]);

    // PC register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            PC <= RESET_PC;
        end else if (LD_PC) begin
            PC <= PC_next;
        end
    end

    // Condition-code register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            NZP <= RESET_NZP;
        end else if (LD_CC) begin
            NZP <= nzp_bus;
        end
    end

    // Branch-enable register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            BEN <= 1'b0;
        end else if (LD_BEN) begin
            BEN <= ben_next;
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed steps followed by random strobes,
// all compared against a behavioural model of the PC/NZP/BEN rules.
module tb_pc_branch_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        LD_PC = 1'b0;
    logic [1:0]  PCMUX = 2'b00;
    logic        LD_CC = 1'b0;
    logic        LD_BEN = 1'b0;
    logic [15:0] BUS = 16'h0000;
    logic [15:0] offset = 16'h0000;
    logic [15:0] IR = 16'h0000;
    logic [15:0] PC;
    logic [15:0] PC_next;
    logic [2:0]  NZP;
    logic        BEN;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic [2:0]  m_nzp;
    logic        m_ben;

    pc_branch_unit dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .LD_PC   (LD_PC),
        .PCMUX   (PCMUX),
        .LD_CC   (LD_CC),
        .LD_BEN  (LD_BEN),
        .BUS     (BUS),
        .offset  (offset),
        .IR      (IR),
        .PC      (PC),
        .PC_next (PC_next),
        .NZP     (NZP),
        .BEN     (BEN)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_pc_next(input logic [1:0] sel, input logic [15:0] bus,
                                                  input logic [15:0] off);
        unique case (sel)
            2'd0:    return 16'((32'(m_pc) + 1) % 65536);
            2'd1:    return bus;
            2'd2:    return off;
            default: return m_pc;
        endcase
    endfunction

    function automatic logic [2:0] classify(input logic [15:0] v);
        if (v == 16'd0)       return 3'b010;
        else if (v >= 16'h8000) return 3'b100;
        else                  return 3'b001;
    endfunction

    function automatic logic branch_taken(input logic [2:0] cond, input logic [2:0] codes);
        return (cond & codes) != 3'b000;
    endfunction

    task automatic model_reset();
        m_pc  = 16'h0000;
        m_nzp = 3'b010;
        m_ben = 1'b0;
    endtask

    // One clock of stimulus: drive, check PC_next, clock, update model, check state
    task automatic step(input string tag, input logic ldpc, input logic [1:0] sel, input logic ldcc,
                        input logic ldben, input logic [15:0] bus, input logic [15:0] off,
                        input logic [15:0] ir);
        logic [15:0] exp_next;
        logic [2:0]  old_nzp;
        LD_PC = ldpc; PCMUX = sel; LD_CC = ldcc; LD_BEN = ldben;
        BUS = bus; offset = off; IR = ir;
        #1;
        exp_next = model_pc_next(sel, bus, off);
        check({tag, ".pc_next"}, PC_next, exp_next);
        @(posedge Clk);
        old_nzp = m_nzp;
        if (ldpc)  m_pc = exp_next;
        if (ldcc)  m_nzp = classify(bus);
        if (ldben) m_ben = branch_taken(ir[11:9], old_nzp);
        #1;
        check({tag, ".pc"}, PC, m_pc);
        check({tag, ".nzp"}, 16'(NZP), 16'(m_nzp));
        check({tag, ".ben"}, 16'(BEN), 16'(m_ben));
        $display("step %s ldpc=%0d sel=%0d ldcc=%0d ldben=%0d bus=%h off=%h ir=%h -> pc=%h nzp=%b ben=%0d",
                 tag, ldpc, sel, ldcc, ldben, bus, off, ir, PC, NZP, BEN);
    endtask

    initial begin
        model_reset();
        // Reset held across edges while LD_PC strobes increment attempts
        LD_PC = 1'b1; PCMUX = 2'b00; LD_CC = 1'b1; BUS = 16'h8000;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            check("rst_hold.pc", PC, 16'h0000);
            check("rst_hold.nzp", 16'(NZP), 16'h0002);
            check("rst_hold.ben", 16'(BEN), 16'h0000);
        end
        LD_CC = 1'b0;
        Reset = 1'b0;
        #1;
        check("rst_release.pc", PC, 16'h0000);

        // Sequential increments
        step("inc1", 1, 2'b00, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step("inc2", 1, 2'b00, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        step("inc3", 1, 2'b00, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        check("inc3.abs", PC, 16'h0003);

        // Wrap from FFFF, then offset load
        step("ld_ffff", 1, 2'b01, 0, 0, 16'hFFFF, 16'h0000, 16'h0000);
        step("wrap", 1, 2'b00, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        check("wrap.abs", PC, 16'h0000);
        step("offset", 1, 2'b10, 0, 0, 16'h0000, 16'h3A5C, 16'h0000);
        check("offset.abs", PC, 16'h3A5C);

        // Condition codes
        step("cc_8000", 0, 2'b00, 1, 0, 16'h8000, 16'h0000, 16'h0000);
        check("cc_8000.abs", 16'(NZP), 16'h0004);
        step("cc_0000", 0, 2'b00, 1, 0, 16'h0000, 16'h0000, 16'h0000);
        check("cc_0000.abs", 16'(NZP), 16'h0002);
        step("cc_7fff", 0, 2'b00, 1, 0, 16'h7FFF, 16'h0000, 16'h0000);
        check("cc_7fff.abs", 16'(NZP), 16'h0001);
        step("cc_0001", 0, 2'b00, 1, 0, 16'h0001, 16'h0000, 16'h0000);
        check("cc_0001.abs", 16'(NZP), 16'h0001);

        // Branch enable, including simultaneous LD_CC
        step("set_n", 0, 2'b00, 1, 0, 16'h8000, 16'h0000, 16'h0000);
        step("ben_n", 0, 2'b00, 0, 1, 16'h0000, 16'h0000, 16'h0800);
        check("ben_n.abs", 16'(BEN), 16'h0001);
        step("ben_oldnzp", 0, 2'b00, 1, 1, 16'h0000, 16'h0000, 16'h0200);
        check("ben_oldnzp.abs", 16'(BEN), 16'h0000);
        check("ben_oldnzp.nzp", 16'(NZP), 16'h0002);
        step("ben_z", 0, 2'b00, 0, 1, 16'h0000, 16'h0000, 16'h0400);
        check("ben_z.abs", 16'(BEN), 16'h0001);

        // Reserved PCMUX holds PC
        step("rsvd", 1, 2'b11, 0, 0, 16'hBEEF, 16'hCAFE, 16'h0000);
        check("rsvd.abs", PC, 16'h3A5C);

        // Random strobes and data
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom));
        end

        // Mid-cycle asynchronous reset
        step("pre_rst", 1, 2'b01, 1, 0, 16'hABCD, 16'h0000, 16'h0000);
        LD_PC = 1'b1; PCMUX = 2'b01; BUS = 16'h1234; LD_CC = 1'b1; LD_BEN = 1'b1; IR = 16'h0E00;
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst.pc", PC, 16'h0000);
        check("async_rst.nzp", 16'(NZP), 16'h0002);
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            check("rst_mid_hold.pc", PC, 16'h0000);
            check("rst_mid_hold.ben", 16'(BEN), 16'h0000);
        end
        Reset = 1'b0;
        model_reset();
        step("post_rst", 1, 2'b01, 0, 0, 16'h1234, 16'h0000, 16'h0000);
        check("post_rst.abs", PC, 16'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
